ship_controller: RTL and testbench

Parametrised player-ship block for the Asteroids display pipeline. It holds the ship position and moves it in four directions once per frame tick with screen wrap-around. An explicit life-cycle state machine (alive, exploding, respawning) responds to a hit input. Each clock it evaluates the scan coordinate against the ship shape and drives registered RGB, ready to be OR-ed with the other sprite layers ahead of the VGA output.

---
 rtl/ast_pkg.sv | 27 ++
 rtl/ship_shape.sv | 34 +++
 rtl/ship_controller.sv | 165 ++++++++++++++++
 tb/tb_ship_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ast_pkg.sv
// Shared types and constants for the Asteroids display pipeline sprite blocks.
package ast_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    EXPLODE,
    RESPAWN
  } ship_state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Per-channel on/off masks; each bit is replicated across COLOR_W by the user.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_mask_t;

  localparam rgb_mask_t WHITE = '{r: 1'b1, g: 1'b1, b: 1'b1};
  localparam rgb_mask_t RED   = '{r: 1'b1, g: 1'b0, b: 1'b0};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ship_shape.sv
// Combinational ship outline test: rectangular body plus a one-pixel-wide nose.
module ship_shape #(
  parameter int COORD_W  = 10,
  parameter int HALF_W   = 10,
  parameter int HALF_H   = 10,
  parameter int NOSE_LEN = 12
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] ship_x,
  input  logic [COORD_W-1:0] ship_y,
  output logic               lit
);

  localparam int DW = COORD_W + 1;

  logic signed [DW-1:0] dx;
  logic signed [DW-1:0] dy;
  logic        [DW-1:0] adx;
  logic        [DW-1:0] ady;
  logic                 body;
  logic                 nose;

  always_comb begin
    dx   = signed'({1'b0, x}) - signed'({1'b0, ship_x});
    dy   = signed'({1'b0, y}) - signed'({1'b0, ship_y});
    adx  = dx[DW-1] ? unsigned'(-dx) : unsigned'(dx);
    ady  = dy[DW-1] ? unsigned'(-dy) : unsigned'(dy);
    body = (adx < DW'(HALF_W)) && (ady < DW'(HALF_H));
    nose = (dx == '0) && (ady < DW'(NOSE_LEN));
    lit  = body | nose;
  end

endmodule

// File: rtl/ship_controller.sv
// Player ship: position with wrap-around movement, hit/explode/respawn life cycle,
// and a registered pixel layer for the scan coordinate.
module ship_controller #(
  parameter int SCREEN_W       = ast_pkg::SCREEN_W,
  parameter int SCREEN_H       = ast_pkg::SCREEN_H,
  parameter int COORD_W        = 10,
  parameter int COLOR_W        = 10,
  parameter int STEP           = 2,
  parameter int HALF_W         = 10,
  parameter int HALF_H         = 10,
  parameter int NOSE_LEN       = 12,
  parameter int START_X        = 320,
  parameter int START_Y        = 240,
  parameter int FLASH_FRAMES   = 60,
  parameter int RESPAWN_FRAMES = 30
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               left,
  input  logic               right,
  input  logic               up,
  input  logic               down,
  input  logic               hit,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               pix_on,
  output logic [COORD_W-1:0] ship_x,
  output logic [COORD_W-1:0] ship_y,
  output logic               alive
);

  import ast_pkg::*;

  localparam int FC_W = $clog2(max_int(FLASH_FRAMES, RESPAWN_FRAMES) + 1);
  localparam int XW   = COORD_W + 1;
  localparam logic [XW-1:0] STEP_E = XW'(STEP);
  localparam logic [XW-1:0] W_E    = XW'(SCREEN_W);
  localparam logic [XW-1:0] H_E    = XW'(SCREEN_H);

  ship_state_e        state_q, state_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic [COORD_W-1:0] ship_x_q, ship_x_d;
  logic [COORD_W-1:0] ship_y_q, ship_y_d;
  logic               lit;
  logic               pix_d;
  rgb_mask_t          mask_d;

  // Extra bit keeps pos+STEP and pos+lim-STEP from overflowing before the wrap compare.
  function automatic logic [COORD_W-1:0] step_axis(
    input logic [COORD_W-1:0] pos,
    input logic               inc,
    input logic               dec,
    input logic [XW-1:0]      lim
  );
    logic [XW-1:0] p;
    p = {1'b0, pos};
    if (inc && !dec)
      p = (p + STEP_E >= lim) ? p + STEP_E - lim : p + STEP_E;
    else if (dec && !inc)
      p = (p < STEP_E) ? p + lim - STEP_E : p - STEP_E;
    return p[COORD_W-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    fc_d     = fc_q;
    ship_x_d = ship_x_q;
    ship_y_d = ship_y_q;
    case (state_q)
      ALIVE: begin
        if (hit) begin
          state_d = EXPLODE;
          fc_d    = FC_W'(FLASH_FRAMES);
        end else if (frame_tick) begin
          ship_x_d = step_axis(ship_x_q, right, left, W_E);
          ship_y_d = step_axis(ship_y_q, down, up, H_E);
        end
      end
      EXPLODE: begin
        if (frame_tick) begin
          if (fc_q == FC_W'(1)) begin
            state_d = RESPAWN;
            fc_d    = FC_W'(RESPAWN_FRAMES);
          end else begin
            fc_d = fc_q - 1'b1;
          end
        end
      end
      RESPAWN: begin
        if (frame_tick) begin
          if (fc_q == FC_W'(1)) begin
            state_d  = ALIVE;
            fc_d     = '0;
            ship_x_d = COORD_W'(START_X);
            ship_y_d = COORD_W'(START_Y);
          end else begin
            fc_d = fc_q - 1'b1;
          end
        end
      end
      default: state_d = ALIVE;
    endcase
  end

  ship_shape #(
    .COORD_W (COORD_W),
    .HALF_W  (HALF_W),
    .HALF_H  (HALF_H),
    .NOSE_LEN(NOSE_LEN)
  ) u_shape (
    .x     (x),
    .y     (y),
    .ship_x(ship_x_q),
    .ship_y(ship_y_q),
    .lit   (lit)
  );

  // Explosion flashes in 4-frame halves of the frame counter.
  always_comb begin
    pix_d  = 1'b0;
    mask_d = '0;
    case (state_q)
      ALIVE: begin
        pix_d  = lit;
        mask_d = lit ? WHITE : '0;
      end
      EXPLODE: begin
        pix_d  = lit & fc_q[2];
        mask_d = pix_d ? RED : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ALIVE;
      fc_q     <= '0;
      ship_x_q <= COORD_W'(START_X);
      ship_y_q <= COORD_W'(START_Y);
      red      <= '0;
      green    <= '0;
      blue     <= '0;
      pix_on   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fc_q     <= fc_d;
      ship_x_q <= ship_x_d;
      ship_y_q <= ship_y_d;
      red      <= {COLOR_W{mask_d.r}};
      green    <= {COLOR_W{mask_d.g}};
      blue     <= {COLOR_W{mask_d.b}};
      pix_on   <= pix_d;
    end
  end

  assign ship_x = ship_x_q;
  assign ship_y = ship_y_q;
  assign alive  = (state_q == ALIVE);

endmodule

// File: tb/tb_ship_controller.sv
// Directed bench for ship_controller: pixel vectors, movement/wrap, life cycle, async reset.
module tb_ship_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick, left, right, up, down, hit;
  logic [9:0] x, y;
  logic [9:0] red, green, blue;
  logic       pix_on, alive;
  logic [9:0] ship_x, ship_y;

  logic       ft2, l2, r2, u2, d2;
  logic [9:0] red2, green2, blue2, ship_x2, ship_y2;
  logic       pix_on2, alive2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ship_controller dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .left(left), .right(right), .up(up), .down(down), .hit(hit),
    .x(x), .y(y), .red(red), .green(green), .blue(blue), .pix_on(pix_on),
    .ship_x(ship_x), .ship_y(ship_y), .alive(alive)
  );

  ship_controller #(.START_X(1), .START_Y(0)) dut2 (
    .clk(clk), .resetn(resetn), .frame_tick(ft2),
    .left(l2), .right(r2), .up(u2), .down(d2), .hit(1'b0),
    .x(10'd0), .y(10'd0), .red(red2), .green(green2), .blue(blue2), .pix_on(pix_on2),
    .ship_x(ship_x2), .ship_y(ship_y2), .alive(alive2)
  );

  typedef struct {
    logic [9:0] px;
    logic [9:0] py;
    logic       pix;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } pvec_t;

  pvec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic tick2();
    ft2 = 1'b1;
    @(posedge clk); #1;
    ft2 = 1'b0;
  endtask

  task automatic sample(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    resetn = 1'b0;
    #2 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int fc_m;
    resetn = 1'b0;
    {frame_tick, left, right, up, down, hit} = '0;
    {ft2, l2, r2, u2, d2} = '0;
    x = 10'd0;
    y = 10'd0;

    vecs[0]  = '{10'd320, 10'd240, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
    vecs[1]  = '{10'd331, 10'd240, 1'b0, 10'h000, 10'h000, 10'h000};
    vecs[2]  = '{10'd320, 10'd251, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
    vecs[3]  = '{10'd329, 10'd249, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
    vecs[4]  = '{10'd330, 10'd240, 1'b0, 10'h000, 10'h000, 10'h000};
    vecs[5]  = '{10'd311, 10'd231, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
    vecs[6]  = '{10'd310, 10'd240, 1'b0, 10'h000, 10'h000, 10'h000};
    vecs[7]  = '{10'd320, 10'd228, 1'b0, 10'h000, 10'h000, 10'h000};
    vecs[8]  = '{10'd320, 10'd229, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
    vecs[9]  = '{10'd321, 10'd251, 1'b0, 10'h000, 10'h000, 10'h000};
    vecs[10] = '{10'd0,   10'd0,   1'b0, 10'h000, 10'h000, 10'h000};

    #12;
    chk("rst red", red, 0);
    chk("rst green", green, 0);
    chk("rst blue", blue, 0);
    chk("rst pix_on", pix_on, 0);
    chk("rst alive", alive, 1);
    chk("rst ship_x", ship_x, 320);
    chk("rst ship_y", ship_y, 240);
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      sample(vecs[i].px, vecs[i].py);
      chk($sformatf("vec%0d pix_on", i), pix_on, vecs[i].pix);
      chk($sformatf("vec%0d red", i), red, vecs[i].r);
      chk($sformatf("vec%0d green", i), green, vecs[i].g);
      chk($sformatf("vec%0d blue", i), blue, vecs[i].b);
    end

    right = 1'b1;
    repeat (3) tick();
    chk("right3 ship_x", ship_x, 326);
    chk("right3 ship_y", ship_y, 240);
    left = 1'b1;
    tick();
    chk("both ship_x", ship_x, 326);
    left = 1'b0;
    for (int n = 0; n < 400 && ship_x != 10'd638; n++) tick();
    chk("reach 638", ship_x, 638);
    tick();
    chk("wrap right x", ship_x, 0);
    right = 1'b0;
    left = 1'b1;
    tick();
    chk("wrap left x", ship_x, 638);
    left = 1'b0;
    up = 1'b1;
    for (int n = 0; n < 400 && ship_y != 10'd0; n++) tick();
    chk("reach y0", ship_y, 0);
    tick();
    chk("wrap up y", ship_y, 478);
    chk("up keeps x", ship_x, 638);
    up = 1'b0;
    down = 1'b1;
    tick();
    chk("wrap down y", ship_y, 0);
    down = 1'b0;

    chk("dut2 start x", ship_x2, 1);
    l2 = 1'b1;
    tick2();
    chk("dut2 left wrap x", ship_x2, 639);
    l2 = 1'b0;
    r2 = 1'b1;
    tick2();
    chk("dut2 right wrap x", ship_x2, 1);
    r2 = 1'b0;
    u2 = 1'b1;
    tick2();
    chk("dut2 up wrap y", ship_y2, 478);
    u2 = 1'b0;

    reset_dut();
    right = 1'b1;
    hit = 1'b1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    {right, hit, frame_tick} = '0;
    chk("hit ship_x", ship_x, 320);
    chk("hit alive", alive, 0);

    fc_m = 60;
    for (int i = 0; i < 60; i++) begin
      hit = (i % 7 == 3);
      sample(320, 240);
      chk($sformatf("explode%0d red", i), red, fc_m[2] ? 10'h3FF : 10'h000);
      chk($sformatf("explode%0d green", i), green, 0);
      hit = (i % 5 == 1);
      tick();
      hit = 1'b0;
      if (i < 59) begin
        fc_m--;
        chk($sformatf("explode%0d alive", i), alive, 0);
      end
    end
    for (int i = 0; i < 30; i++) begin
      sample(320, 240);
      chk($sformatf("respawn%0d pix_on", i), pix_on, 0);
      chk($sformatf("respawn%0d red", i), red, 0);
      hit = (i % 4 == 0);
      tick();
      hit = 1'b0;
      chk($sformatf("respawn%0d alive", i), alive, (i == 29) ? 1 : 0);
    end
    chk("respawn ship_x", ship_x, 320);
    chk("respawn ship_y", ship_y, 240);
    sample(320, 240);
    chk("respawn white pix", pix_on, 1);
    chk("respawn white blue", blue, 10'h3FF);

    hit = 1'b1;
    @(posedge clk); #1;
    hit = 1'b0;
    sample(320, 240);
    chk("pre-reset red", red, 10'h3FF);
    #2 resetn = 1'b0;
    #1;
    chk("midrst red", red, 0);
    chk("midrst pix_on", pix_on, 0);
    chk("midrst alive", alive, 1);
    chk("midrst ship_x", ship_x, 320);
    chk("midrst ship_y", ship_y, 240);
    #2 resetn = 1'b1;
    sample(320, 240);
    chk("postrst pix_on", pix_on, 1);
    chk("postrst red", red, 10'h3FF);
    chk("postrst green", green, 10'h3FF);
    chk("postrst blue", blue, 10'h3FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
